inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Responder end of the instruction-fetch interface driven by the program counter register.
- Accepts program_counter/chip_enable requests and serves 32-bit instructions from an internal word memory after a configurable number of wait states.
- While busy, raises stall_request, which the stall controller uses to build bit 0 of the stop_all bus. This freezes the PC.
- A load port fills the memory, driven by the boot loader or the bench.

Parameters:
- DEPTH_LOG2, 10: memory holds 2**DEPTH_LOG2 32-bit words.
- WAIT_STATES, 2: extra cycles per fetch, legal range 0..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- chip_enable  input  1  fetch request, from the PC register.
- program_counter  input  32  byte address of the requested instruction.
- flush  input  1  branch/exception redirect; aborts an in-flight fetch.
- load_valid  input  1  memory write strobe.
- load_address  input  DEPTH_LOG2  word index to write.
- load_data  input  32  word to write.
- instruction  output  32  fetched instruction.
- instruction_valid  output  1  one-cycle pulse; instruction is valid.
- stall_request  output  1  fetch in progress; PC must hold.
- address_error  output  1  set together with instruction_valid for a misaligned or out-of-range address.

Behaviour:
- Reset (asynchronous): state IDLE; instruction = 0; instruction_valid, stall_request and address_error = 0; wait counter = 0. Memory contents are not reset.
- All outputs are registered.
- State IDLE:
  - Request accepted on an edge where chip_enable=1 and flush=0.
  - On acceptance, latch index = program_counter[DEPTH_LOG2+1:2] and error = (program_counter[1:0]!=0) or (program_counter[31:DEPTH_LOG2+2]!=0).
  - WAIT_STATES=0: go to RESP. Otherwise go to WAIT with counter = WAIT_STATES.
- State WAIT:
  - stall_request=1.
  - Counter decrements each edge. When it reaches 0, go to RESP.
- Transition into RESP:
  - instruction <= error ? 0 : mem[index]. Value 0 is a NOP.
  - instruction_valid <= 1 and address_error <= error, for exactly one cycle.
  - stall_request <= 0.
- State RESP: if chip_enable=1 and flush=0, accept a new request back-to-back (same rules as IDLE). Otherwise go to IDLE.
- Latency: instruction_valid is high WAIT_STATES+1 cycles after the accepting edge. Throughput is one fetch per WAIT_STATES+1 cycles.
- Flush:
  - In WAIT: abort, go to IDLE, no valid pulse; stall_request drops next cycle.
  - Flush takes priority over a simultaneous new request, which is not accepted.
- chip_enable deasserted during WAIT: abort to IDLE, no valid pulse.
- Load port:
  - Write occurs on the edge with load_valid=1.
  - A read of the same index on the same edge returns the old data (read-before-write).
- Reset asserted mid-fetch: immediate return to the reset values; no partial response.

Optional Feature:
- Macro: INST_FETCH_LAST_HIT_EN.
- With the macro defined:
  - A one-entry tag (index + valid bit) records the last successfully served index.
  - An accepted request matching the tag skips WAIT and goes straight to RESP (latency 1, no stall_request).
  - The tag is invalidated by reset, by flush, or by a load write to the tagged index.
  - Error responses never set the tag.
- Without the macro: every fetch takes WAIT_STATES+1 cycles; no tag logic is present.

Decomposition:
- Shared defines header (defines.v): InstructionAddressBus, InstructionBus, ChipEnable/ChipDisable, ZeroWord, fetch state encodings (IDLE/WAIT/RESP), stall bit position within StopAllBus.
- One sub-module: inst_mem_array. Synchronous single-port-read, single-port-write word memory with read-before-write; no reset.

Test Plan:
- Load mem[0..3] = 0x11111111..0x44444444; WAIT_STATES=2; chip_enable=1, program_counter=0x0 -> stall_request high 2 cycles; instruction=0x11111111 with valid 3 cycles after the accepting edge.
- Back-to-back program_counter 0x4 then 0x8 held via the stall -> valid pulses 3 cycles apart carrying 0x22222222 then 0x33333333; no gap cycle in IDLE.
- program_counter=0x6 -> instruction=0x00000000, address_error=1. program_counter=0x00100000 with DEPTH_LOG2=10 -> same error response.
- Flush asserted in the second WAIT cycle -> no valid pulse; stall_request low next cycle; a fetch of 0xC then returns 0x44444444.
- Load write to index 1 on the RESP-entry edge of a fetch of 0x4 -> old value returned; a refetch returns the new value. Reset mid-WAIT -> all outputs 0 immediately.
- With INST_FETCH_LAST_HIT_EN defined:
  - A repeat fetch of 0x4 -> valid 1 cycle after acceptance, no stall_request.
  - After a load write to index 1, the same fetch -> full 3-cycle latency.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package inst_fetch_responder_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 4;
  // Position of this block's stall line within the stop_all bus.
  localparam int unsigned STALL_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  // Misaligned or beyond the memory: answered with a NOP and address_error.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] pc,
                                    input int unsigned depth_log2);
    return (pc[1:0] != 2'b00) || ((pc >> (depth_log2 + 2)) != '0);
  endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch request/response and memory load signals between PC side and responder.
interface inst_fetch_responder_if
  import inst_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  chip_enable;
  logic [ADDR_W-1:0]     program_counter;
  logic                  flush;
  logic                  load_valid;
  logic [DEPTH_LOG2-1:0] load_address;
  logic [WORD_W-1:0]     load_data;
  logic [WORD_W-1:0]     instruction;
  logic                  instruction_valid;
  logic                  stall_request;
  logic                  address_error;

  modport master (
    output chip_enable, program_counter, flush, load_valid, load_address, load_data,
    input  instruction, instruction_valid, stall_request, address_error
  );

  modport slave (
    input  chip_enable, program_counter, flush, load_valid, load_address, load_data,
    output instruction, instruction_valid, stall_request, address_error
  );
endinterface

// File: rtl/inst_fetch_responder_mem_array.sv
// Word memory: synchronous read into a resettable output register, read-before-write.
module inst_mem_array
  import inst_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WORD_W-1:0]     rd_data
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem_array [DEPTH];
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  // Storage is never reset; contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_array[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : mem_array[rd_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder with configurable wait states.
// Optional last-index hit bypass: define INST_FETCH_LAST_HIT_EN.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                   clock,
  input logic                   reset,
  inst_fetch_responder_if.slave bus
);
  localparam logic [CNT_W-1:0] WS      = CNT_W'(WAIT_STATES);
  localparam bit               NO_WAIT = (WAIT_STATES == 0);

  fetch_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  stall_q, stall_d;
  logic                  aerr_q, aerr_d;

  logic                  accept_c, hit_c, req_err_c;
  logic [DEPTH_LOG2-1:0] req_idx_c;
  logic                  rd_en_c, rd_zero_c;
  logic [DEPTH_LOG2-1:0] rd_addr_c;
  logic [WORD_W-1:0]     rd_data;

  assign accept_c  = bus.chip_enable && !bus.flush;
  assign req_idx_c = bus.program_counter[DEPTH_LOG2+1:2];
  assign req_err_c = addr_bad(bus.program_counter, DEPTH_LOG2);

`ifdef INST_FETCH_LAST_HIT_EN
  logic [DEPTH_LOG2-1:0] tag_idx_q, tag_idx_d;
  logic                  tag_vld_q, tag_vld_d;

  assign hit_c = tag_vld_q && (tag_idx_q == req_idx_c) && !req_err_c;

  // A good response tags its index; flush or a write to the tagged word drops it.
  always_comb begin
    tag_idx_d = tag_idx_q;
    tag_vld_d = tag_vld_q;
    if (rd_en_c && !rd_zero_c) begin
      tag_idx_d = rd_addr_c;
      tag_vld_d = 1'b1;
    end
    if (bus.flush || (bus.load_valid && (bus.load_address == tag_idx_d))) tag_vld_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_idx_q <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      tag_idx_q <= tag_idx_d;
      tag_vld_q <= tag_vld_d;
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    aerr_d    = 1'b0;
    stall_d   = 1'b0;
    rd_en_c   = 1'b0;
    rd_addr_c = idx_q;
    rd_zero_c = err_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          idx_d = req_idx_c;
          err_d = req_err_c;
          if (NO_WAIT || hit_c) begin
            state_d   = ST_RESP;
            cnt_d     = '0;
            valid_d   = 1'b1;
            aerr_d    = req_err_c;
            rd_en_c   = 1'b1;
            rd_addr_c = req_idx_c;
            rd_zero_c = req_err_c;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
            stall_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.flush || !bus.chip_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          valid_d = 1'b1;
          aerr_d  = err_q;
          rd_en_c = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      aerr_q  <= aerr_d;
    end
  end

  inst_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.load_valid),
    .wr_addr (bus.load_address),
    .wr_data (bus.load_data),
    .rd_en   (rd_en_c),
    .rd_zero (rd_zero_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  assign bus.instruction       = rd_data;
  assign bus.instruction_valid = valid_q;
  assign bus.stall_request     = stall_q;
  assign bus.address_error     = aerr_q;
endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder (DEPTH_LOG2=10, WAIT_STATES=2).
module tb_inst_fetch_responder;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  inst_fetch_responder_if #(.DEPTH_LOG2(10)) bus ();

  inst_fetch_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Response monitor: every valid pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && bus.instruction_valid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid instr=%08h err=%0b expected no response",
                 bus.instruction, bus.address_error);
      end else begin
        e = sb.pop_front();
        if (bus.instruction !== e.data || bus.address_error !== e.err) begin
          errors++;
          $display("FAIL response instr=%08h err=%0b expected instr=%08h err=%0b",
                   bus.instruction, bus.address_error, e.data, e.err);
        end
      end
    end
    if (!reset && !bus.instruction_valid && bus.address_error) begin
      checks++;
      errors++;
      $display("FAIL error_without_valid address_error=1 expected 0");
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic load_word(input logic [9:0] idx, input logic [31:0] d);
    bus.load_valid   = 1'b1;
    bus.load_address = idx;
    bus.load_data    = d;
    @(negedge clock);
    bus.load_valid = 1'b0;
  endtask

  // Issue one fetch from a negedge; measure latency and stall cycles.
  task automatic do_fetch(input logic [31:0] pc, input int exp_lat, input int exp_stall);
    int cyc    = 0;
    int stalls = 0;
    bit seen   = 0;
    bus.program_counter = pc;
    bus.chip_enable     = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (bus.stall_request) stalls++;
      if (bus.instruction_valid) seen = 1;
    end
    bus.chip_enable = 1'b0;
    checks++;
    if (!seen || cyc != exp_lat) begin
      errors++;
      $display("FAIL latency pc=%08h got=%0d seen=%0b expected=%0d", pc, cyc, seen, exp_lat);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL stall_cycles pc=%08h got=%0d expected=%0d", pc, stalls, exp_stall);
    end
    @(negedge clock);
    checks++;
    if (bus.instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width pc=%08h valid=%0b expected 0", pc, bus.instruction_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.chip_enable = 1'b0;
    bus.program_counter = '0;
    bus.flush = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_address = '0;
    bus.load_data = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.instruction !== 32'h0 || bus.instruction_valid !== 1'b0 ||
        bus.stall_request !== 1'b0 || bus.address_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs instr=%08h v=%0b s=%0b e=%0b expected all 0",
               bus.instruction, bus.instruction_valid, bus.stall_request, bus.address_error);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.instruction_valid !== 1'b0 || bus.stall_request !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle v=%0b s=%0b expected 0 0",
               bus.instruction_valid, bus.stall_request);
    end
  endtask

  task automatic test_basic();
    load_word(10'd0, 32'h11111111);
    load_word(10'd1, 32'h22222222);
    load_word(10'd2, 32'h33333333);
    load_word(10'd3, 32'h44444444);
    push(32'h11111111, 1'b0);
    do_fetch(32'h0, 3, 2);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int first = 0;
    int second = 0;
    push(32'h22222222, 1'b0);
    push(32'h33333333, 1'b0);
    bus.program_counter = 32'h4;
    bus.chip_enable = 1'b1;
    while (second == 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (bus.instruction_valid) begin
        if (first == 0) begin
          first = cyc;
          bus.program_counter = 32'h8;
        end else begin
          second = cyc;
        end
      end else if (first != 0 && cyc == first + 1) begin
        checks++;
        if (bus.stall_request !== 1'b1) begin
          errors++;
          $display("FAIL b2b_no_gap stall=%0b expected 1", bus.stall_request);
        end
      end
    end
    bus.chip_enable = 1'b0;
    checks++;
    if (first != 3 || second - first != 3) begin
      errors++;
      $display("FAIL b2b_spacing first=%0d second=%0d expected first=3 second=6", first, second);
    end
    @(negedge clock);
  endtask

  task automatic test_addr_error();
    push(32'h0, 1'b1);
    do_fetch(32'h6, 3, 2);
    push(32'h0, 1'b1);
    do_fetch(32'h00100000, 3, 2);
  endtask

  task automatic test_flush();
    bus.program_counter = 32'h0;
    bus.chip_enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.stall_request !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_stall stall=%0b expected 1", bus.stall_request);
    end
    bus.flush = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.stall_request !== 1'b0 || bus.instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort stall=%0b valid=%0b expected 0 0",
               bus.stall_request, bus.instruction_valid);
    end
    bus.flush = 1'b0;
    bus.chip_enable = 1'b0;
    repeat (3) @(negedge clock);
    push(32'h44444444, 1'b0);
    do_fetch(32'hC, 3, 2);
  endtask

  task automatic test_abort_and_priority();
    // chip_enable dropped mid-wait
    bus.program_counter = 32'h0;
    bus.chip_enable = 1'b1;
    @(negedge clock);
    bus.chip_enable = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.stall_request !== 1'b0) begin
      errors++;
      $display("FAIL ce_abort stall=%0b expected 0", bus.stall_request);
    end
    repeat (3) @(negedge clock);
    // flush wins over a simultaneous request
    bus.chip_enable = 1'b1;
    bus.flush = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.stall_request !== 1'b0 || bus.instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority stall=%0b valid=%0b expected 0 0",
               bus.stall_request, bus.instruction_valid);
    end
    bus.chip_enable = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_read_before_write();
    push(32'h22222222, 1'b0);
    bus.program_counter = 32'h4;
    bus.chip_enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.load_valid = 1'b1;
    bus.load_address = 10'd1;
    bus.load_data = 32'hA5A55A5A;
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.chip_enable = 1'b0;
    checks++;
    if (bus.instruction_valid !== 1'b1) begin
      errors++;
      $display("FAIL rbw_valid valid=%0b expected 1", bus.instruction_valid);
    end
    @(negedge clock);
    push(32'hA5A55A5A, 1'b0);
    do_fetch(32'h4, 3, 2);
  endtask

  task automatic test_reset_mid_wait();
    bus.program_counter = 32'h0;
    bus.chip_enable = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.stall_request !== 1'b1) begin
      errors++;
      $display("FAIL midwait_stall stall=%0b expected 1", bus.stall_request);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.instruction !== 32'h0 || bus.instruction_valid !== 1'b0 ||
        bus.stall_request !== 1'b0 || bus.address_error !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset instr=%08h v=%0b s=%0b e=%0b expected all 0",
               bus.instruction, bus.instruction_valid, bus.stall_request, bus.address_error);
    end
    bus.chip_enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

`ifdef INST_FETCH_LAST_HIT_EN
  task automatic test_last_hit();
    push(32'hA5A55A5A, 1'b0);
    do_fetch(32'h4, 3, 2);
    push(32'hA5A55A5A, 1'b0);
    do_fetch(32'h4, 1, 0);
    load_word(10'd1, 32'h0BADF00D);
    push(32'h0BADF00D, 1'b0);
    do_fetch(32'h4, 3, 2);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_addr_error();
    test_flush();
    test_abort_and_priority();
    test_read_before_write();
    test_reset_mid_wait();
`ifdef INST_FETCH_LAST_HIT_EN
    test_last_hit();
`endif
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
